prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Serial program loader that sits directly upstream of the Simplez program/data RAM and drives its address, read/write and write-data inputs.
- Consumes a byte stream from the UART receiver (one-cycle `rx_valid` strobe per byte).
- Assembles DW-bit words and writes them sequentially into RAM from address 0.
- Holds the CPU while loading and reports done, error and checksum.

Parameters:
- AW, 9, RAM address width; NPOS = 2**AW words.
- DW, 12, RAM data width; legal range 9..16 (two bytes per word).
- TIMEOUT, 1200000, idle cycles tolerated between bytes of one load before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, `rx_data` valid
- ram_addr  out  AW  RAM address
- ram_rw  out  1  1 = read, 0 = write (RAM polarity)
- ram_data  out  DW  RAM write data
- busy  out  1  load in progress
- done  out  1  last load completed cleanly
- err  out  1  last load aborted
- checksum  out  DW  mod-2**DW sum of words written in current/last load
- cpu_hold  out  1  CPU must stall while high

Behaviour:
- All outputs registered.
- Reset values: `ram_addr` 0, `ram_rw` 1, `ram_data` 0, `busy` 0, `done` 0, `err` 0, `checksum` 0, `cpu_hold` 0. State goes to IDLE.
- Wire protocol: count_hi, count_lo, then per word hi, lo.
  - count is a 16-bit big-endian word count.
  - Word = {hi[DW-9:0], lo}; unused upper hi bits are ignored.
- States: IDLE, CNT_LO, WAIT_HI, WAIT_LO, DONE, ERR.
- IDLE/DONE/ERR + `rx_valid`: byte taken as count_hi. Clear `done`, `err`, `checksum` and the word index; set `busy` and `cpu_hold`; go to CNT_LO.
- CNT_LO + `rx_valid`: form count.
  - count == 0 -> DONE.
  - count > NPOS -> ERR.
  - otherwise -> WAIT_HI.
- WAIT_HI + `rx_valid`: latch hi byte; go to WAIT_LO.
- WAIT_LO + `rx_valid`, next cycle:
  - `ram_data` = {hi, lo}, `ram_addr` = index, `ram_rw` = 0 for exactly one cycle.
  - `checksum` += word.
  - Next state: WAIT_HI, or DONE if index == count-1.
- Index increments in the cycle after the write strobe. `ram_rw` returns to 1 that cycle; `ram_addr` holds its last written value.
- Write latency: strobe in the cycle immediately after the low byte's `rx_valid`.
- `rx_valid` in the strobe cycle is accepted normally; no byte is dropped.
- DONE: `busy` 0, `cpu_hold` 0, `done` 1. `checksum` holds the final sum.
- ERR: `busy` 0, `err` 1, `cpu_hold` stays 1 (partial image must not run). Exit only via a new count_hi byte or `rst`.
- Timeout:
  - Counter cleared on every `rx_valid` and in IDLE/DONE/ERR.
  - In CNT_LO/WAIT_HI/WAIT_LO, reaching TIMEOUT-1 without a byte -> ERR next cycle.
  - `rx_valid` in the same cycle as expiry wins: the byte is accepted and there is no error.
- Wrap: index never exceeds NPOS-1, guaranteed by the count check. count == NPOS writes every location.
- `rst` mid-load: immediate return to IDLE with reset values. No further writes; RAM contents already written remain.
- `checksum` is a DW-bit sum; overflow wraps.

Decomposition:
- Shared header `loader_defs.vh`: state encodings, RW_READ = 1 / RW_WRITE = 0 constants, BYTES_PER_WORD = 2.
- One sub-module `rx_timeout`: parameterised down-counter with clear/enable inputs and one-cycle expiry output.
- Word assembly and FSM stay in `prog_loader`.

Test Plan:
- Bytes 00 03 01 0A 00 FF 0E 01 -> three single-cycle writes:
  - addr 0 = 0x10A, addr 1 = 0x0FF, addr 2 = 0xE01;
  - then `done` = 1, `checksum` = 0x00A, `cpu_hold` = 0.
- Bytes 00 00 -> DONE one cycle after second byte; no `ram_rw` = 0 cycle; `checksum` 0.
- Bytes 02 01 (513 > 512) -> ERR after count_lo; no writes; `cpu_hold` stays 1. Then 00 01 F3 45 -> addr 0 = 0x345, `err` cleared, `done` = 1.
- Bytes 00 02 01, then no `rx_valid` for TIMEOUT cycles -> `err` = 1 exactly at expiry; no write issued. Repeat with a byte arriving on the expiry cycle -> no error.
- Back-to-back `rx_valid` every cycle for 00 02 AA BB CC DD -> writes 0xABB@0, 0xCDD@1; none lost.
- `rst` asserted between a word's hi and lo bytes -> all outputs at reset values next cycle; subsequent lo byte treated as count_hi.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the Simplez serial program loader: FSM state
// encodings, RAM read/write polarity and wire-format constants.
package prog_loader_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CNT_LO  = 3'd1;
   localparam logic [2:0] ST_WAIT_HI = 3'd2;
   localparam logic [2:0] ST_WAIT_LO = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;
   localparam logic [2:0] ST_ERR     = 3'd5;

   // RAM read/write strobe polarity as seen by the Simplez RAM
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Every RAM word travels as a hi byte followed by a lo byte
   localparam int BYTES_PER_WORD = 2;

   // The word count header is a 16-bit big-endian value
   localparam int COUNT_W = 16;

   // True in the states where a load is in flight and the idle timer runs
   function automatic logic is_loading(input logic [2:0] st);
      return (st == ST_CNT_LO) || (st == ST_WAIT_HI) || (st == ST_WAIT_LO);
   endfunction

endpackage

// File: rtl/prog_loader_rx_timeout.sv
// Inter-byte idle timer: a down-counter that is reloaded whenever a byte
// arrives (or the loader is not loading) and flags expiry for one cycle
// when the last tolerated idle cycle passes without a byte.
module rx_timeout
   import prog_loader_pkg::*;
#(
   parameter int TIMEOUT = 1200000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Reload on clear, otherwise count down while enabled and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = LOAD;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Counter register, reloaded on reset so a fresh load starts full
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A byte arriving on the expiry cycle clears the timer, so it suppresses expiry
   assign expire = enable && !clear && (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader for the Simplez RAM. Takes a UART byte stream
// (count_hi, count_lo, then hi/lo per word), writes words from address 0,
// holds the CPU while loading and reports done/err/checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int AW      = 9,
   parameter int DW      = 12,
   parameter int TIMEOUT = 1200000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rw,
   output logic [DW-1:0] ram_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] checksum,
   output logic          cpu_hold
);

   // Number of meaningful bits carried by the hi byte of each word
   localparam int HI_BITS = DW - 8 * (BYTES_PER_WORD - 1);
   // RAM depth widened so a count equal to the depth compares correctly
   localparam logic [COUNT_W:0] NPOS_EXT = (COUNT_W + 1)'(2 ** AW);

   logic [2:0]         state_q,    state_d;
   logic [COUNT_W-1:0] count_q,    count_d;
   logic [HI_BITS-1:0] hi_q,       hi_d;
   logic [AW-1:0]      index_q,    index_d;
   logic [AW-1:0]      ram_addr_q, ram_addr_d;
   logic               ram_rw_q,   ram_rw_d;
   logic [DW-1:0]      ram_data_q, ram_data_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               err_q,      err_d;
   logic [DW-1:0]      checksum_q, checksum_d;
   logic               cpu_hold_q, cpu_hold_d;

   logic               loading;
   logic               tmo_expire;
   logic [COUNT_W-1:0] count_w;
   logic [DW-1:0]      word_w;
   logic               last_word;

   assign loading   = is_loading(state_q);
   assign count_w   = {count_q[COUNT_W-1:8], rx_data};
   assign word_w    = {hi_q, rx_data};
   assign last_word = ({{(COUNT_W - AW){1'b0}}, index_q} == (count_q - COUNT_W'(1)));

   rx_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_rx_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (rx_valid || !loading),
      .enable (loading),
      .expire (tmo_expire)
   );

   // Next-state, word assembly and registered-output computation
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      hi_d       = hi_q;
      index_d    = index_q;
      ram_addr_d = ram_addr_q;
      ram_rw_d   = RW_READ;
      ram_data_d = ram_data_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      checksum_d = checksum_q;
      cpu_hold_d = cpu_hold_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (rx_valid) begin
               count_d    = {rx_data, 8'h00};
               index_d    = '0;
               checksum_d = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               cpu_hold_d = 1'b1;
               state_d    = ST_CNT_LO;
            end
         end

         ST_CNT_LO: begin
            if (rx_valid) begin
               count_d = count_w;
               if (count_w == '0) begin
                  busy_d     = 1'b0;
                  cpu_hold_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_DONE;
               end else if ({1'b0, count_w} > NPOS_EXT) begin
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_WAIT_HI;
               end
            end else if (tmo_expire) begin
               busy_d  = 1'b0;
               err_d   = 1'b1;
               state_d = ST_ERR;
            end
         end

         ST_WAIT_HI: begin
            if (rx_valid) begin
               hi_d    = rx_data[HI_BITS-1:0];
               state_d = ST_WAIT_LO;
            end else if (tmo_expire) begin
               busy_d  = 1'b0;
               err_d   = 1'b1;
               state_d = ST_ERR;
            end
         end

         ST_WAIT_LO: begin
            if (rx_valid) begin
               ram_data_d = word_w;
               ram_addr_d = index_q;
               ram_rw_d   = RW_WRITE;
               checksum_d = checksum_q + word_w;
               index_d    = index_q + AW'(1);
               if (last_word) begin
                  busy_d     = 1'b0;
                  cpu_hold_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  state_d = ST_WAIT_HI;
               end
            end else if (tmo_expire) begin
               busy_d  = 1'b0;
               err_d   = 1'b1;
               state_d = ST_ERR;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset to the idle values
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         hi_q       <= '0;
         index_q    <= '0;
         ram_addr_q <= '0;
         ram_rw_q   <= RW_READ;
         ram_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         checksum_q <= '0;
         cpu_hold_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         hi_q       <= hi_d;
         index_q    <= index_d;
         ram_addr_q <= ram_addr_d;
         ram_rw_q   <= ram_rw_d;
         ram_data_q <= ram_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         checksum_q <= checksum_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_rw   = ram_rw_q;
   assign ram_data = ram_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign checksum = checksum_q;
   assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected RAM writes go into a
// scoreboard queue as bytes are driven and are matched when the DUT strobes.
module tb_prog_loader;

   localparam int AW  = 9;
   localparam int DW  = 12;
   localparam int TMO = 16;

   typedef struct {
      int          addr;
      logic [11:0] data;
      int          stamp;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic [AW-1:0] ram_addr;
   logic          ram_rw;
   logic [DW-1:0] ram_data;
   logic          busy;
   logic          done;
   logic          err;
   logic [DW-1:0] checksum;
   logic          cpu_hold;

   int            vectors = 0;
   int            miscompares = 0;
   int            cycleCnt = 0;
   wr_t           sb[$];
   logic [11:0]   modelSum;

   prog_loader #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .ram_addr (ram_addr),
      .ram_rw   (ram_rw),
      .ram_data (ram_data),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .checksum (checksum),
      .cpu_hold (cpu_hold)
   );

   // Free-running clock and cycle stamp used to check write latency
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one byte with rx_valid for the next clock edge
   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   // Called right after the lo byte is driven: strobe due on the next cycle
   task automatic expectWrite(input int addr, input logic [11:0] data);
      wr_t w;
      w.addr  = addr;
      w.data  = data;
      w.stamp = cycleCnt + 1;
      sb.push_back(w);
      modelSum = modelSum + data;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
      checkOutput({tag, " ram_rw"},   32'(ram_rw),   32'h1);
      checkOutput({tag, " ram_data"}, 32'(ram_data), 32'h0);
      checkOutput({tag, " busy"},     32'(busy),     32'h0);
      checkOutput({tag, " done"},     32'(done),     32'h0);
      checkOutput({tag, " err"},      32'(err),      32'h0);
      checkOutput({tag, " checksum"}, 32'(checksum), 32'h0);
      checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'h0);
   endtask

   // Write monitor: every write strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && ram_rw === 1'b0) begin
         if (sb.size() == 0) begin
            checkOutput("spurious write", 32'(sb.size()), 32'h1);
         end else begin
            wr_t w;
            w = sb.pop_front();
            checkOutput("write addr",  32'(ram_addr), 32'(w.addr));
            checkOutput("write data",  32'(ram_data), 32'(w.data));
            checkOutput("write cycle", 32'(cycleCnt), 32'(w.stamp));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [11:0] d;

      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;

      $display("[TB] three-word load");
      modelSum = '0;
      applyStimulus(8'h00);
      idleCycles(1);
      checkOutput("load busy",     32'(busy),     32'h1);
      checkOutput("load cpu_hold", 32'(cpu_hold), 32'h1);
      applyStimulus(8'h03);
      applyStimulus(8'h01); applyStimulus(8'h0A); expectWrite(0, 12'h10A);
      idleCycles(2);
      applyStimulus(8'h00); applyStimulus(8'hFF); expectWrite(1, 12'h0FF);
      applyStimulus(8'h0E); idleCycles(1);
      applyStimulus(8'h01); expectWrite(2, 12'hE01);
      idleCycles(1);
      checkOutput("t1 done",     32'(done),     32'h1);
      checkOutput("t1 checksum", 32'(checksum), 32'h00A);
      checkOutput("t1 cpu_hold", 32'(cpu_hold), 32'h0);
      checkOutput("t1 busy",     32'(busy),     32'h0);
      idleCycles(1);
      checkOutput("t1 addr hold", 32'(ram_addr), 32'h2);
      checkOutput("t1 rw back",   32'(ram_rw),   32'h1);

      $display("[TB] zero-count load");
      applyStimulus(8'h00); applyStimulus(8'h00);
      idleCycles(1);
      checkOutput("t2 done",     32'(done),     32'h1);
      checkOutput("t2 checksum", 32'(checksum), 32'h0);
      checkOutput("t2 busy",     32'(busy),     32'h0);

      $display("[TB] oversize count then recovery");
      applyStimulus(8'h02); applyStimulus(8'h01);
      idleCycles(1);
      checkOutput("t3 err",      32'(err),      32'h1);
      checkOutput("t3 cpu_hold", 32'(cpu_hold), 32'h1);
      checkOutput("t3 busy",     32'(busy),     32'h0);
      checkOutput("t3 done",     32'(done),     32'h0);
      modelSum = '0;
      applyStimulus(8'h00);
      idleCycles(1);
      checkOutput("t3 err cleared", 32'(err), 32'h0);
      applyStimulus(8'h01); applyStimulus(8'hF3);
      applyStimulus(8'h45); expectWrite(0, 12'h345);
      idleCycles(1);
      checkOutput("t3 done",     32'(done),     32'h1);
      checkOutput("t3 checksum", 32'(checksum), 32'h345);
      checkOutput("t3 released", 32'(cpu_hold), 32'h0);

      $display("[TB] inter-byte timeout");
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h01);
      idleCycles(TMO);
      checkOutput("t4 err before expiry", 32'(err), 32'h0);
      checkOutput("t4 busy before expiry", 32'(busy), 32'h1);
      idleCycles(1);
      checkOutput("t4 err at expiry", 32'(err),      32'h1);
      checkOutput("t4 busy at expiry", 32'(busy),    32'h0);
      checkOutput("t4 hold at expiry", 32'(cpu_hold), 32'h1);

      $display("[TB] byte on the expiry cycle");
      modelSum = '0;
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h01);
      idleCycles(TMO - 1);
      applyStimulus(8'h22); expectWrite(0, 12'h122);
      idleCycles(1);
      checkOutput("t4b err",  32'(err),  32'h0);
      checkOutput("t4b busy", 32'(busy), 32'h1);
      applyStimulus(8'h03); applyStimulus(8'h44); expectWrite(1, 12'h344);
      idleCycles(1);
      checkOutput("t4b done",     32'(done),     32'h1);
      checkOutput("t4b checksum", 32'(checksum), 32'(modelSum));

      $display("[TB] back-to-back bytes");
      modelSum = '0;
      applyStimulus(8'h00); applyStimulus(8'h02);
      applyStimulus(8'hAA); applyStimulus(8'hBB); expectWrite(0, 12'hABB);
      applyStimulus(8'hCC); applyStimulus(8'hDD); expectWrite(1, 12'hCDD);
      idleCycles(1);
      checkOutput("t5 done",     32'(done),     32'h1);
      checkOutput("t5 checksum", 32'(checksum), 32'h798);

      $display("[TB] full-depth load");
      modelSum = '0;
      applyStimulus(8'h02); applyStimulus(8'h00);
      for (int i = 0; i < (1 << AW); i++) begin
         d = 12'(i * 7 + 3);
         applyStimulus({4'h0, d[11:8]});
         applyStimulus(d[7:0]);
         expectWrite(i, d);
      end
      idleCycles(1);
      checkOutput("t6 done",     32'(done),     32'h1);
      checkOutput("t6 err",      32'(err),      32'h0);
      checkOutput("t6 checksum", 32'(checksum), 32'(modelSum));
      checkOutput("t6 last addr", 32'(ram_addr), 32'((1 << AW) - 1));

      $display("[TB] reset between hi and lo");
      applyStimulus(8'h00); applyStimulus(8'h02);
      applyStimulus(8'h56); applyStimulus(8'h78); expectWrite(0, 12'h678);
      applyStimulus(8'h12);
      idleCycles(1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkResetState("midload reset");
      rst = 1'b0;
      applyStimulus(8'h34);
      idleCycles(1);
      checkOutput("t7 busy",     32'(busy),     32'h1);
      checkOutput("t7 cpu_hold", 32'(cpu_hold), 32'h1);
      applyStimulus(8'h00);
      idleCycles(1);
      checkOutput("t7 count_hi err", 32'(err), 32'h1);
      idleCycles(3);

      checkOutput("pending writes", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
